program_loader: RTL and testbench

Boot-time writer for the instruction store. It accepts a framed little-endian byte stream over a valid/ready interface and assembles it into 32-bit words. Each word is written into program memory through a write port at consecutive word-aligned byte addresses. The processor core is held off (`processor_hold`) until the image has been written in full and its checksum has verified.

---
 rtl/program_loader_pkg.sv | 20 ++
 rtl/program_loader_word_assembler.sv | 34 +++
 rtl/program_loader.sv | 128 ++++++++++++
 tb/tb_program_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package program_loader_pkg;

   typedef enum logic [2:0] {
      HEADER   = 3'd0,
      PAYLOAD  = 3'd1,
      CHECKSUM = 3'd2,
      DONE     = 3'd3,
      ERROR    = 3'd4
   } load_state_t;

   localparam int HEADER_BYTES   = 4;
   localparam int BYTES_PER_WORD = 4;

   // Frame checksum is a plain XOR over header and payload bytes.
   function automatic logic [7:0] xor_accumulate(input logic [7:0] acc, input logic [7:0] data);
      return acc ^ data;
   endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Collects four little-endian bytes into a 32-bit word; used for both header and payload.
module word_assembler
   import program_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        shift_enable,
   input  logic [7:0]  byte_data,
   output logic        word_ready,
   output logic [31:0] word_value
);

   logic [1:0]  byte_count_r;
   logic [23:0] shift_r;

   // The word completes combinationally with the 4th byte so the caller can act on the same edge.
   assign word_ready = shift_enable && (byte_count_r == 2'(BYTES_PER_WORD - 1));
   assign word_value = {byte_data, shift_r};

   // Byte counter and shift-in register; the counter wraps to 0 after each word.
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_count_r <= 2'd0;
         shift_r      <= 24'd0;
      end else if (shift_enable) begin
         byte_count_r <= byte_count_r + 2'd1;
         shift_r      <= {byte_data, shift_r[23:8]};
      end else begin
         byte_count_r <= byte_count_r;
         shift_r      <= shift_r;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream, writes program memory, and releases the core
// only after the whole image has arrived with a matching checksum.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int unsigned MAX_WORDS    = 1024,
   parameter logic [31:0] BASE_ADDRESS = 32'd0
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        memory_write_enabled,
   output logic [31:0] memory_write_address,
   output logic [31:0] memory_write_value,
   output logic        processor_hold,
   output logic        load_complete,
   output logic        load_error
);

   localparam int IDX_W = $clog2(MAX_WORDS + 1);

   load_state_t      state_r;
   logic [IDX_W-1:0] word_index_r;
   logic [IDX_W-1:0] word_count_r;
   logic [7:0]       running_xor_r;

   logic             accept_s;
   logic             shift_enable_s;
   logic             word_ready_s;
   logic [31:0]      word_value_s;
   logic [IDX_W-1:0] next_index_s;

   // Ready is a pure function of state so the source sees refusal immediately in terminal states.
   always_comb begin
      byte_ready = 1'b0;
      if (reset) begin
         byte_ready = 1'b0;
      end else begin
         case (state_r)
            HEADER, PAYLOAD, CHECKSUM: byte_ready = 1'b1;
            default:                   byte_ready = 1'b0;
         endcase
      end
   end

   assign accept_s       = byte_valid && byte_ready;
   assign shift_enable_s = accept_s && ((state_r == HEADER) || (state_r == PAYLOAD));
   assign next_index_s   = word_index_r + IDX_W'(1);

   word_assembler u_word_assembler (
      .clk          (clk),
      .reset        (reset),
      .shift_enable (shift_enable_s),
      .byte_data    (byte_data),
      .word_ready   (word_ready_s),
      .word_value   (word_value_s)
   );

   // Frame state machine with registered memory write port and status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r              <= HEADER;
         word_index_r         <= '0;
         word_count_r         <= '0;
         running_xor_r        <= 8'd0;
         memory_write_enabled <= 1'b0;
         memory_write_address <= 32'd0;
         memory_write_value   <= 32'd0;
         processor_hold       <= 1'b1;
         load_complete        <= 1'b0;
         load_error           <= 1'b0;
      end else begin
         memory_write_enabled <= 1'b0;
         case (state_r)
            HEADER: begin
               if (accept_s) begin
                  running_xor_r <= xor_accumulate(running_xor_r, byte_data);
               end
               // The count is judged as a full 32-bit value before it is narrowed.
               if (word_ready_s) begin
                  if (word_value_s > 32'(MAX_WORDS)) begin
                     state_r    <= ERROR;
                     load_error <= 1'b1;
                  end else if (word_value_s == 32'd0) begin
                     state_r <= CHECKSUM;
                  end else begin
                     state_r      <= PAYLOAD;
                     word_count_r <= IDX_W'(word_value_s);
                  end
               end
            end
            PAYLOAD: begin
               if (accept_s) begin
                  running_xor_r <= xor_accumulate(running_xor_r, byte_data);
               end
               if (word_ready_s) begin
                  memory_write_enabled <= 1'b1;
                  memory_write_address <= BASE_ADDRESS + (32'(word_index_r) << 2);
                  memory_write_value   <= word_value_s;
                  word_index_r         <= next_index_s;
                  if (next_index_s == word_count_r) begin
                     state_r <= CHECKSUM;
                  end
               end
            end
            CHECKSUM: begin
               if (accept_s) begin
                  if (byte_data == running_xor_r) begin
                     state_r        <= DONE;
                     load_complete  <= 1'b1;
                     processor_hold <= 1'b0;
                  end else begin
                     state_r    <= ERROR;
                     load_error <= 1'b1;
                  end
               end
            end
            default: begin
               state_r <= state_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a frame-level reference model.
module tb_program_loader;

   localparam int unsigned MAX_WORDS = 1024;
   localparam logic [31:0] BASE      = 32'd0;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'd0;
   logic        byte_ready;
   logic        memory_write_enabled;
   logic [31:0] memory_write_address;
   logic [31:0] memory_write_value;
   logic        processor_hold;
   logic        load_complete;
   logic        load_error;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] payload_q[$];
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_value_q[$];
   logic [31:0] obs_addr_q[$];
   logic [31:0] obs_value_q[$];
   int          wide_strobes = 0;
   bit          prev_we = 1'b0;

   program_loader #(.MAX_WORDS(MAX_WORDS), .BASE_ADDRESS(BASE)) dut (
      .clk                  (clk),
      .reset                (reset),
      .byte_valid           (byte_valid),
      .byte_data            (byte_data),
      .byte_ready           (byte_ready),
      .memory_write_enabled (memory_write_enabled),
      .memory_write_address (memory_write_address),
      .memory_write_value   (memory_write_value),
      .processor_hold       (processor_hold),
      .load_complete        (load_complete),
      .load_error           (load_error)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Record every write strobe seen on the memory port.
   always @(negedge clk) begin
      if (memory_write_enabled === 1'b1) begin
         obs_addr_q.push_back(memory_write_address);
         obs_value_q.push_back(memory_write_value);
         if (prev_we) wide_strobes++;
      end
      prev_we = (memory_write_enabled === 1'b1);
   end

   task automatic do_reset();
      @(negedge clk);
      reset      = 1'b1;
      byte_valid = 1'b0;
      @(negedge clk);
      check_value("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
      check_value("rst_we", {31'd0, memory_write_enabled}, 32'd0);
      check_value("rst_addr", memory_write_address, 32'd0);
      check_value("rst_value", memory_write_value, 32'd0);
      check_value("rst_hold", {31'd0, processor_hold}, 32'd1);
      check_value("rst_complete", {31'd0, load_complete}, 32'd0);
      check_value("rst_error", {31'd0, load_error}, 32'd0);
      reset = 1'b0;
      obs_addr_q.delete();
      obs_value_q.delete();
      exp_addr_q.delete();
      exp_value_q.delete();
      wide_strobes = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_max, output bit accepted);
      repeat ($urandom_range(0, gap_max)) begin
         @(negedge clk);
         byte_valid = 1'b0;
      end
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      accepted   = byte_ready;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic compare_writes(input string tag);
      int n;
      check_value({tag, "_write_count"}, obs_addr_q.size(), exp_addr_q.size());
      n = (obs_addr_q.size() < exp_addr_q.size()) ? obs_addr_q.size() : exp_addr_q.size();
      for (int i = 0; i < n; i++) begin
         check_value({tag, "_addr"}, obs_addr_q[i], exp_addr_q[i]);
         check_value({tag, "_value"}, obs_value_q[i], exp_value_q[i]);
      end
      check_value({tag, "_strobe_width"}, wide_strobes, 32'd0);
      obs_addr_q.delete();
      obs_value_q.delete();
      exp_addr_q.delete();
      exp_value_q.delete();
      wide_strobes = 0;
   endtask

   // Reference model: build the frame, predict writes and outcome, then drive and compare.
   task automatic run_frame(input string tag, input logic [31:0] n, input logic [7:0] sum_mask, input int gap_max);
      logic [7:0] bytes_q[$];
      logic [7:0] sum;
      logic [31:0] w;
      bit acc;
      bit oversize;
      bit ok;
      oversize = (n > MAX_WORDS);
      for (int i = 0; i < 4; i++) bytes_q.push_back(8'((n >> (8 * i)) & 32'hFF));
      if (!oversize) begin
         for (int i = 0; i < int'(n); i++) begin
            w = (i < payload_q.size()) ? payload_q[i] : $urandom;
            for (int k = 0; k < 4; k++) bytes_q.push_back(8'((w >> (8 * k)) & 32'hFF));
            exp_addr_q.push_back(BASE + 32'(4 * i));
            exp_value_q.push_back(w);
         end
      end
      sum = 8'd0;
      foreach (bytes_q[i]) sum = sum ^ bytes_q[i];
      ok = !oversize && (sum_mask == 8'd0);

      for (int i = 0; i < bytes_q.size(); i++) begin
         send_byte(bytes_q[i], gap_max, acc);
         check_value({tag, "_accept"}, {31'd0, acc}, 32'd1);
         if (i >= 4 && ((i - 4) % 4) == 3)
            check_value({tag, "_write_latency"}, {31'd0, memory_write_enabled}, 32'd1);
      end
      if (oversize) begin
         check_value({tag, "_err_latency"}, {31'd0, load_error}, 32'd1);
         send_byte(8'h5A, 0, acc);
         check_value({tag, "_post_err_accept"}, {31'd0, acc}, 32'd0);
      end else begin
         check_value({tag, "_pre_sum_complete"}, {31'd0, load_complete}, 32'd0);
         send_byte(sum ^ sum_mask, gap_max, acc);
         check_value({tag, "_sum_accept"}, {31'd0, acc}, 32'd1);
         check_value({tag, "_complete_latency"}, {31'd0, load_complete}, {31'd0, ok});
         check_value({tag, "_error_latency"}, {31'd0, load_error}, {31'd0, !ok});
      end
      repeat (3) @(negedge clk);
      check_value({tag, "_complete"}, {31'd0, load_complete}, {31'd0, ok});
      check_value({tag, "_error"}, {31'd0, load_error}, {31'd0, !ok});
      check_value({tag, "_hold"}, {31'd0, processor_hold}, {31'd0, !ok});
      check_value({tag, "_ready_after"}, {31'd0, byte_ready}, 32'd0);
      compare_writes(tag);
      payload_q.delete();
   endtask

   initial begin
      bit acc;
      logic [31:0] n;
      logic [7:0]  mask;

      do_reset();
      payload_q = '{32'hDEADBEEF};
      run_frame("n1_good", 32'd1, 8'h00, 0);

      do_reset();
      run_frame("n0", 32'd0, 8'h00, 0);

      do_reset();
      payload_q = '{32'hDEADBEEF};
      run_frame("n1_badsum", 32'd1, 8'h07, 0);

      do_reset();
      run_frame("oversize_1025", 32'd1025, 8'h00, 0);

      do_reset();
      run_frame("oversize_wide", 32'h0001_0001, 8'h00, 1);

      do_reset();
      payload_q = '{32'h00000013, 32'h00100093};
      run_frame("n2_gaps", 32'd2, 8'h00, 3);

      // Abort a frame after two payload bytes, then load a fresh image.
      do_reset();
      send_byte(8'h01, 0, acc);
      send_byte(8'h00, 0, acc);
      send_byte(8'h00, 0, acc);
      send_byte(8'h00, 0, acc);
      send_byte(8'hAA, 0, acc);
      send_byte(8'hBB, 0, acc);
      do_reset();
      payload_q = '{32'h12345678};
      run_frame("abort_reload", 32'd1, 8'h00, 0);

      do_reset();
      run_frame("max_words", 32'(MAX_WORDS), 8'h00, 0);

      for (int it = 0; it < 10; it++) begin
         n    = 32'($urandom_range(0, 6));
         mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         do_reset();
         run_frame("random", n, mask, $urandom_range(0, 3));
      end

      do_reset();
      run_frame("random_oversize", 32'($urandom_range(1025, 32'h00FF_FFFF)), 8'h00, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
